fetch_redirect_ctrl: RTL

Sequences the fetch PC register and arbitrates redirect sources for the dual-issue front end: exception, ID2 mispredict flush, and branch-predictor taken. It handles the delay-slot split when a predicted-taken branch sits in the upper word of a fetch pair. It presents each fetch address to the I-cache under a valid/ready handshake and holds redirects that arrive while a request is stalled. Sits between the branch predictor / ID2 flush logic and the I-cache request port.

---
 rtl/fetch_redirect_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC sequencer and redirect arbiter for the
// dual-issue front end. Priorities: exception > ID2 flush > predictor taken.
// A predicted-taken branch in the upper word of a fetch pair is split. The
// delay slot is fetched alone (fetch_ds=1), and the saved target follows it.
// Redirects that arrive while a request is stalled are held until accept.
// Optional feature macro: FETCH_REDIRECT_PERF_EN enables the exc/flush/drop
// performance counters. When it is not defined, the counter outputs read 0.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid,
    output logic [31:0]      fetch_pc,
    input  logic             fetch_ready,
    output logic             fetch_ds,
    output logic             fetch_drop,
    input  logic             exc_req,
    input  logic [31:0]      exc_pc,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    output logic [1:0]       redirect_src,
    output logic [CNT_W-1:0] exc_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {S_SEQ, S_DS} state_t;

    localparam logic [1:0] SRC_SEQ   = 2'd0;
    localparam logic [1:0] SRC_PRED  = 2'd1;
    localparam logic [1:0] SRC_FLUSH = 2'd2;
    localparam logic [1:0] SRC_EXC   = 2'd3;

    state_t      state_reg, state_next;
    logic        valid_reg;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ds_target_reg, ds_target_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic [1:0]  pend_src_reg, pend_src_next;

    logic        accept;
    logic        pend_is_exc;
    logic        eff_valid;
    logic [31:0] eff_pc;
    logic [1:0]  eff_src;
    logic [31:0] seq_pc;

    assign accept      = valid_reg & fetch_ready;
    assign pend_is_exc = pend_valid_reg && (pend_src_reg == SRC_EXC);
    // A 4-byte fetch at an upper word only advances to the next pair.
    assign seq_pc      = pc_reg[2] ? (pc_reg + 32'd4) : (pc_reg + 32'd8);

    assign fetch_valid = valid_reg;
    assign fetch_pc    = pc_reg;
    assign fetch_ds    = (state_reg == S_DS);

    // Merge new requests with the held one. A new exception always wins. A new
    // flush cannot displace a held exception.
    always_comb begin
        eff_valid = 1'b0;
        eff_pc    = pend_pc_reg;
        eff_src   = pend_src_reg;
        if (exc_req) begin
            eff_valid = 1'b1;
            eff_pc    = exc_pc;
            eff_src   = SRC_EXC;
        end else if (flush_req && !pend_is_exc) begin
            eff_valid = 1'b1;
            eff_pc    = flush_pc;
            eff_src   = SRC_FLUSH;
        end else if (pend_valid_reg) begin
            eff_valid = 1'b1;
        end
    end

    // Next-state, next-PC and per-accept outputs for the SEQ/DS sequencer.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ds_target_next  = ds_target_reg;
        pend_valid_next = pend_valid_reg;
        pend_pc_next    = pend_pc_reg;
        pend_src_next   = pend_src_reg;
        redirect_src    = SRC_SEQ;
        fetch_drop      = 1'b0;
        if (accept) begin
            if (eff_valid) begin
                // The request handed over now is already stale.
                fetch_drop      = 1'b1;
                pc_next         = eff_pc;
                redirect_src    = eff_src;
                state_next      = S_SEQ;
                pend_valid_next = 1'b0;
            end else if (state_reg == S_DS) begin
                pc_next      = ds_target_reg;
                redirect_src = SRC_PRED;
                state_next   = S_SEQ;
            end else if (pred_taken) begin
                if (pc_reg[2]) begin
                    // The branch is in the upper word. Fetch its delay slot first.
                    pc_next        = pc_reg + 32'd4;
                    ds_target_next = pred_target;
                    state_next     = S_DS;
                end else begin
                    pc_next      = pred_target;
                    redirect_src = SRC_PRED;
                end
            end else begin
                pc_next = seq_pc;
            end
        end else if (eff_valid) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = eff_pc;
            pend_src_next   = eff_src;
        end
    end

    // State and datapath registers. Reset drops any held redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_SEQ;
            valid_reg      <= 1'b0;
            pc_reg         <= RESET_PC;
            ds_target_reg  <= 32'd0;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= 32'd0;
            pend_src_reg   <= SRC_SEQ;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= 1'b1;
            pc_reg         <= pc_next;
            ds_target_reg  <= ds_target_next;
            pend_valid_reg <= pend_valid_next;
            pend_pc_reg    <= pend_pc_next;
            pend_src_reg   <= pend_src_next;
        end
    end

`ifdef FETCH_REDIRECT_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc[0] = accept & eff_valid & (eff_src == SRC_EXC);
    assign cnt_inc[1] = accept & eff_valid & (eff_src == SRC_FLUSH);
    assign cnt_inc[2] = fetch_drop;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        // Saturating event counter.
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
    end

    assign exc_cnt   = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];
    assign drop_cnt  = cnt_reg[2];
`else
    assign exc_cnt   = '0;
    assign flush_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule
